rf_op_sequencer: RTL
====================

Name: rf_op_sequencer

Overview:
- Initiator/master for the 8x8-bit `register_file`. It drives the write-side and read-address ports (WEN, RW, busW, RX, RY) and consumes the read buses (busX, busY).
- Accepts three-operand commands over a valid/ready handshake, reads two source registers, computes an 8-bit ALU result and writes it back to the destination register.
- Sits between the simple-calculator control front end and `register_file`, and is the only agent driving the register file's inputs.

Parameters:
- DW, 8, data width; must match `register_file` bus width.
- AW, 3, register address width (8 registers).

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode.
- cmd_rd  in  AW  destination register.
- cmd_rs  in  AW  source A register.
- cmd_rt  in  AW  source B register.
- cmd_imm  in  DW  immediate for LI.
- done  out  1  one-cycle completion pulse.
- result  out  DW  computed value, valid while done=1.
- ovf  out  1  carry (ADD) / borrow (SUB), valid while done=1.
- WEN  out  1  register-file write enable.
- RW  out  AW  write address.
- busW  out  DW  write data.
- RX  out  AW  read address X.
- RY  out  AW  read address Y.
- busX  in  DW  register-file read data X (combinational from RX).
- busY  in  DW  register-file read data Y (combinational from RY).

Behaviour:
- Reset (Rst_n=0 at a rising edge): state=IDLE; latched command, operands, result, ovf, done all cleared to 0. The edge following reset release shows cmd_ready=1 and every other output 0.
- WEN is gated combinationally with Rst_n, so no register-file write commits on any edge where Rst_n=0. A WRITE in progress when reset asserts is abandoned.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE.
  - IDLE: cmd_ready=1. If cmd_valid at the edge, latch op/rd/rs/rt/imm and go to READ.
  - READ: RX=rs, RY=rt. busX/busY are sampled into opA/opB at the end of the cycle.
  - EXEC: result and ovf are computed from opA/opB and registered.
  - WRITE: WEN=1, RW=rd, busW=result. The register file commits at the end of this cycle. Then go to IDLE.
- done=1 for exactly the first IDLE cycle after WRITE; result and ovf are held stable while done=1.
- Latency: accept at edge 0, write commits at edge 3, done high during cycle 3->4. A new command may be accepted in the done cycle, giving back-to-back throughput of 1 command per 4 cycles.
- Idle values: outside READ, RX=RY=0. Outside WRITE, WEN=0, RW=0, busW=0. cmd_ready=0 in READ/EXEC/WRITE.
- Opcodes:
  - 0 ADD: {ovf,result} = opA + opB, 9-bit.
  - 1 SUB: result = opA - opB mod 256; ovf = (opA < opB) unsigned.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLT: result = 1 if signed opA < signed opB, else 0.
  - 6 LI: result = imm; read cycle still executed.
  - 7 NOP: no write.
  - ovf=0 for every op other than ADD/SUB.
- Write suppression: with op=NOP or rd=0, WEN stays 0 in WRITE (register 0 is hard-wired zero). done still pulses and result still reports the computed value.
- Sources rs=0 or rt=0 read as 0 through the register file; no special-casing is done here.
- A write-after-write or read-after-write to the same register across consecutive commands is safe: the write commits before the next READ.

Optional Feature:
- Macro: RF_CMD_BUF_EN.
- Defined:
  - A one-entry command buffer is added; cmd_ready = (state==IDLE) | !buf_valid.
  - A command accepted while busy is stored in the buffer.
  - In IDLE with buf_valid=1, the buffered command launches to READ with priority over any new command; a simultaneously accepted new command refills the buffer.
  - Reset clears buf_valid.
- Undefined: no buffer; cmd_ready=1 only in IDLE. Behaviour is exactly as above.

Test Plan:
- Reset: hold Rst_n=0 for 2 cycles with cmd_valid=1 -> no accept, WEN=0, done=0, cmd_ready=1 after release.
- LI then read-back: LI r1, imm=8'hAA; then ADD r2=r1+r0 -> WEN pulse at RW=1/busW=8'hAA, then RW=2/busW=8'hAA; done twice; ovf=0.
- ADD carry: LI r7=8'hFF, LI r3=8'h01, ADD r4=r7+r3 -> busW=8'h00, ovf=1.
- SUB borrow: SUB r5=r3-r7 -> result=8'h02, ovf=1.
- SLT signed: r7=8'hFF, r3=8'h01 -> SLT r6,r7,r3 gives 8'h01.
- Suppression: LI r0, imm=8'hCC and NOP -> WEN never high; done pulses with result 8'hCC; reading r0 still returns 8'h00.
- Reset mid-op: assert Rst_n=0 during the WRITE of LI r3=8'h55 -> register 3 unchanged; FSM back in IDLE.
- With RF_CMD_BUF_EN: hold cmd_valid for 3 commands -> 2nd is accepted while busy; 3rd is stalled until the 1st completes; writes occur in order 4 cycles apart.

Source files
------------

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: command-driven master for an 8x8-bit register file.
// Takes a three-operand command over valid/ready. It reads two source registers,
// computes an ALU result and writes it back to the destination register.
// Each command runs IDLE -> READ -> EXEC -> WRITE, and done pulses in the next IDLE cycle.
//
// Ports:
//   Clk, Rst_n         clock, synchronous active-low reset
//   cmd_valid/ready    command handshake
//   cmd_op/rd/rs/rt    opcode, destination and source register addresses
//   cmd_imm            immediate for LI
//   done/result/ovf    completion pulse with result and carry/borrow
//   WEN/RW/busW        register-file write port (WEN gated by Rst_n)
//   RX/RY, busX/busY   register-file read addresses and combinational read data
//
// Optional feature (macro RF_CMD_BUF_EN): a one-entry command buffer lets a
// command be accepted while the sequencer is busy.
module rf_op_sequencer #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  input  logic [DW-1:0] cmd_imm,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          ovf,
  output logic          WEN,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] busW,
  output logic [AW-1:0] RX,
  output logic [AW-1:0] RY,
  input  logic [DW-1:0] busX,
  input  logic [DW-1:0] busY
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpSlt = 3'd5;
  localparam logic [2:0] OpLi  = 3'd6;
  localparam logic [2:0] OpNop = 3'd7;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  typedef struct packed {
    logic [2:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] imm;
  } cmd_t;

  state_e        state;
  cmd_t          cmd_in;
  cmd_t          cmd_q;
  cmd_t          launch_cmd;
  logic          launch;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic          alu_ovf;
  logic [DW:0]   sum;
  logic          wen_q;
  logic          do_write;

  assign cmd_in = {cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm};

`ifdef RF_CMD_BUF_EN
  logic buf_valid;
  cmd_t buf_cmd;

  assign cmd_ready  = (state == StIdle) | ~buf_valid;
  assign launch     = buf_valid | cmd_valid;
  // An older buffered command always launches ahead of a new one.
  assign launch_cmd = buf_valid ? buf_cmd : cmd_in;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      buf_valid <= 1'b0;
      buf_cmd   <= '0;
    end else if (state == StIdle) begin
      // The buffered entry launches now; a concurrent new command takes its slot.
      if (buf_valid) begin
        buf_valid <= cmd_valid;
        buf_cmd   <= cmd_in;
      end
    end else if (!buf_valid && cmd_valid) begin
      buf_valid <= 1'b1;
      buf_cmd   <= cmd_in;
    end
  end
`else
  assign cmd_ready  = (state == StIdle);
  assign launch     = cmd_valid;
  assign launch_cmd = cmd_in;
`endif

  // Register 0 is hard-wired zero, so writes to it are dropped like NOP.
  assign do_write = (cmd_q.op != OpNop) && (cmd_q.rd != '0);

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (cmd_q.op)
      OpAdd: begin
        sum     = {1'b0, op_a} + {1'b0, op_b};
        alu_res = sum[DW-1:0];
        alu_ovf = sum[DW];
      end
      OpSub: begin
        alu_res = op_a - op_b;
        alu_ovf = (op_a < op_b);
      end
      OpAnd: alu_res = op_a & op_b;
      OpOr:  alu_res = op_a | op_b;
      OpXor: alu_res = op_a ^ op_b;
      OpSlt: alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OpLi:  alu_res = cmd_q.imm;
      OpNop: alu_res = '0;
    endcase
  end

  // Bus outputs are registered for the state being entered, so each is
  // non-zero only during its own state.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= StIdle;
      cmd_q  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      wen_q  <= 1'b0;
      RW     <= '0;
      busW   <= '0;
      RX     <= '0;
      RY     <= '0;
    end else begin
      done  <= 1'b0;
      wen_q <= 1'b0;
      RW    <= '0;
      busW  <= '0;
      RX    <= '0;
      RY    <= '0;
      unique case (state)
        StIdle: begin
          if (launch) begin
            cmd_q <= launch_cmd;
            RX    <= launch_cmd.rs;
            RY    <= launch_cmd.rt;
            state <= StRead;
          end
        end
        StRead: begin
          op_a  <= busX;
          op_b  <= busY;
          state <= StExec;
        end
        StExec: begin
          result <= alu_res;
          ovf    <= alu_ovf;
          wen_q  <= do_write;
          RW     <= cmd_q.rd;
          busW   <= alu_res;
          state  <= StWrite;
        end
        StWrite: begin
          done  <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // No write may commit on an edge where reset is asserted.
  assign WEN = wen_q & Rst_n;

endmodule
